// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises whole 32-bit IF/LSB requests into little-endian byte accesses on the
// 8-bit RAM port. Define MEM_CTRL_IO_STALL_EN to hold writes to 0x30000-0x3FFFF while the UART is full.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module mem_ctrl (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [`REG_WIDTH-1:0]  mem_a,
    output logic                   mem_wr,
    input  logic                   io_buffer_full,
    input  logic                   rob_clear,
    input  logic                   if_signal,
    input  logic [`REG_WIDTH-1:0]  if_addr,
    output logic [`REG_WIDTH-1:0]  if_data,
    output logic                   if_done,
    input  logic                   lsb_signal,
    input  logic                   lsb_wr,
    input  logic [1:0]             lsb_len,
    input  logic [`REG_WIDTH-1:0]  lsb_addr,
    input  logic [`REG_WIDTH-1:0]  lsb_dout,
    output logic [`REG_WIDTH-1:0]  lsb_din,
    output logic                   lsb_done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] READ    = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] IO_WAIT = 2'd3;

    logic [1:0]            state_q;
    logic [`REG_WIDTH-1:0] addr_q;
    logic [`REG_WIDTH-1:0] wdata_q;
    logic [`REG_WIDTH-1:0] rdata_q;
    logic [1:0]            cnt_q;
    logic [1:0]            last_q;
    logic                  owner_lsb_q;

    logic                  accept;
    logic                  req_lsb;
    logic                  req_wr;
    logic [1:0]            req_last;
    logic [`REG_WIDTH-1:0] req_addr;
    logic [1:0]            cnt_nxt;
    logic [`REG_WIDTH-1:0] addr_nxt;
    logic [7:0]            wbyte_nxt;
    logic [`REG_WIDTH-1:0] rdata_new;
    logic                  last_byte;
    logic                  stall_first;
    logic                  stall_next;

    always_comb begin
        req_lsb  = lsb_signal;
        // Both done flags low keeps a client that is still dropping its request from re-entering.
        accept   = (state_q == IDLE) && !rob_clear && !if_done && !lsb_done &&
                   (lsb_signal || if_signal);
        req_addr = req_lsb ? lsb_addr : if_addr;
        req_wr   = req_lsb && lsb_wr;
        if (!req_lsb) begin
            req_last = 2'd3;
        end else begin
            case (lsb_len)
                2'b00:   req_last = 2'd0;
                2'b01:   req_last = 2'd1;
                default: req_last = 2'd3;
            endcase
        end
        cnt_nxt   = cnt_q + 2'd1;
        addr_nxt  = addr_q + {{(`REG_WIDTH-2){1'b0}}, cnt_nxt};
        wbyte_nxt = wdata_q[{cnt_nxt, 3'b000} +: 8];
        // Byte k is on mem_din by the edge that closes cycle k.
        rdata_new = rdata_q;
        rdata_new[{cnt_q, 3'b000} +: 8] = mem_din;
        last_byte = (cnt_q == last_q);
    end

`ifdef MEM_CTRL_IO_STALL_EN
    function automatic logic is_io(input logic [`REG_WIDTH-1:0] a);
        return a[31:16] == 16'h0003;
    endfunction

    assign stall_first = is_io(req_addr) && io_buffer_full;
    assign stall_next  = is_io(addr_nxt) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io   = io_buffer_full;
    assign stall_first = 1'b0;
    assign stall_next  = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= 2'd0;
            last_q      <= 2'd0;
            owner_lsb_q <= 1'b0;
            mem_a       <= '0;
            mem_dout    <= 8'd0;
            mem_wr      <= 1'b0;
            if_data     <= '0;
            if_done     <= 1'b0;
            lsb_din     <= '0;
            lsb_done    <= 1'b0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= req_addr;
                        wdata_q     <= lsb_dout;
                        rdata_q     <= '0;
                        cnt_q       <= 2'd0;
                        last_q      <= req_last;
                        owner_lsb_q <= req_lsb;
                        mem_a       <= req_addr;
                        mem_dout    <= lsb_dout[7:0];
                        if (!req_wr) begin
                            state_q <= READ;
                        end else if (stall_first) begin
                            state_q <= IO_WAIT;
                        end else begin
                            state_q <= WRITE;
                            mem_wr  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rob_clear) begin
                        state_q <= IDLE;
                    end else if (last_byte) begin
                        state_q <= IDLE;
                        if (owner_lsb_q) begin
                            lsb_done <= 1'b1;
                            lsb_din  <= rdata_new;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= rdata_new;
                        end
                    end else begin
                        rdata_q <= rdata_new;
                        cnt_q   <= cnt_nxt;
                        mem_a   <= addr_nxt;
                    end
                end
                WRITE: begin
                    // Committed stores ignore rob_clear and always run to completion.
                    if (last_byte) begin
                        state_q  <= IDLE;
                        mem_wr   <= 1'b0;
                        lsb_done <= 1'b1;
                        lsb_din  <= '0;
                    end else begin
                        cnt_q    <= cnt_nxt;
                        mem_a    <= addr_nxt;
                        mem_dout <= wbyte_nxt;
                        if (stall_next) begin
                            state_q <= IO_WAIT;
                            mem_wr  <= 1'b0;
                        end else begin
                            mem_wr <= 1'b1;
                        end
                    end
                end
`ifdef MEM_CTRL_IO_STALL_EN
                IO_WAIT: begin
                    if (!io_buffer_full) begin
                        state_q <= WRITE;
                        mem_wr  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected done/write events, a negedge monitor pops
// and compares them. Edge numbers count only edges with rdy_in high.
`timescale 1ns/1ps

module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        rob_clear;
    logic        if_signal;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        lsb_signal;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_dout;
    logic [31:0] lsb_din;
    logic        lsb_done;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full),
        .rob_clear     (rob_clear),
        .if_signal     (if_signal),
        .if_addr       (if_addr),
        .if_data       (if_data),
        .if_done       (if_done),
        .lsb_signal    (lsb_signal),
        .lsb_wr        (lsb_wr),
        .lsb_len       (lsb_len),
        .lsb_addr      (lsb_addr),
        .lsb_dout      (lsb_dout),
        .lsb_din       (lsb_din),
        .lsb_done      (lsb_done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] data;
        logic        chk;
        int          edge_n;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          edge_n;
    } wr_t;

    done_t lsb_q[$];
    done_t if_q[$];
    wr_t   wr_q[$];

    int   n_tests = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    logic rdy_live = 1'b0;
    int   hits_2004 = 0;

    // RAM contents seen by reads; combinational read port.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h11;
            32'h0000_1001: return 8'h22;
            32'h0000_1002: return 8'h33;
            32'h0000_1003: return 8'h44;
            32'h0000_0010: return 8'h80;
            32'h0000_0040: return 8'ha1;
            32'h0000_0041: return 8'hb2;
            32'h0000_0042: return 8'hc3;
            32'h0000_0043: return 8'hd4;
            32'hFFFF_FFFE: return 8'h5e;
            32'hFFFF_FFFF: return 8'h6f;
            32'h0000_0000: return 8'h70;
            32'h0000_0001: return 8'h81;
            default:       return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    assign mem_din = init_byte(mem_a);

    always @(posedge clk_in) begin
        rdy_live <= rdy_in;
        if (rdy_in) edge_cnt <= edge_cnt + 1;
        if (!rst_in && rdy_in && mem_wr && mem_a == 32'h0000_2004) hits_2004 <= hits_2004 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen at edge %0d with nothing expected", name, edge_cnt);
    endtask

    // Monitor: only events freshly produced by a live edge are consumed.
    always @(negedge clk_in) begin
        done_t d;
        wr_t   w;
        if (!rst_in && rdy_live) begin
            if (lsb_done) begin
                if (lsb_q.size() == 0) unexpected("lsb_done");
                else begin
                    d = lsb_q.pop_front();
                    chk("lsb_done_edge", edge_cnt, d.edge_n);
                    if (d.chk) chk("lsb_din", lsb_din, d.data);
                end
            end
            if (if_done) begin
                if (if_q.size() == 0) unexpected("if_done");
                else begin
                    d = if_q.pop_front();
                    chk("if_done_edge", edge_cnt, d.edge_n);
                    chk("if_data", if_data, d.data);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) unexpected("mem_wr");
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_a, w.addr);
                    chk("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
                    chk("wr_edge", edge_cnt, w.edge_n);
                end
            end
        end
    end

    // Called at a negedge; off = done edge after accept edge E0, wofs = first write cycle.
    task automatic lsb_req(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp, input int off,
                           input int wofs);
        done_t d;
        wr_t   w;
        int    e0;
        int    n;
        bit    seen;
        e0 = edge_cnt + 1;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        d.data = exp;
        d.chk = !wr;
        d.edge_n = e0 + off;
        lsb_q.push_back(d);
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                w.addr = addr + k;
                w.data = data[8*k +: 8];
                w.edge_n = e0 + wofs + k;
                wr_q.push_back(w);
            end
        end
        lsb_signal = 1'b1;
        lsb_wr = wr;
        lsb_len = len;
        lsb_addr = addr;
        lsb_dout = data;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (lsb_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) unexpected("lsb_timeout");
        lsb_signal = 1'b0;
    endtask

    task automatic if_req(input logic [31:0] addr, input logic [31:0] exp, input int off);
        done_t d;
        bit    seen;
        d.data = exp;
        d.chk = 1'b1;
        d.edge_n = edge_cnt + 1 + off;
        if_q.push_back(d);
        if_signal = 1'b1;
        if_addr = addr;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (if_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) unexpected("if_timeout");
        if_signal = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        rob_clear = 1'b0;
        if_signal = 1'b0;
        if_addr = 32'd0;
        lsb_signal = 1'b0;
        lsb_wr = 1'b0;
        lsb_len = 2'b00;
        lsb_addr = 32'd0;
        lsb_dout = 32'd0;
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_lsb_din", lsb_din, 32'd0);
        chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        // 4-byte load
        lsb_req(1'b0, 2'b10, 32'h0000_1000, 32'd0, 32'h4433_2211, 4, 0);
        @(negedge clk_in);
        // 2-byte store
        lsb_req(1'b1, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 2, 0);
        @(negedge clk_in);
        chk("no_write_2004", hits_2004, 32'd0);

        // Simultaneous requests: LSB wins, IF accepted at E3
        @(negedge clk_in);
        fork
            lsb_req(1'b0, 2'b00, 32'h0000_0010, 32'd0, 32'h0000_0080, 1, 0);
            if_req(32'h0000_0040, 32'hd4c3_b2a1, 7);
        join
        @(negedge clk_in);

        // rob_clear in IDLE delays accept by one edge
        fork
            lsb_req(1'b0, 2'b00, 32'h0000_0010, 32'd0, 32'h0000_0080, 2, 0);
            begin
                rob_clear = 1'b1;
                @(negedge clk_in);
                rob_clear = 1'b0;
            end
        join
        @(negedge clk_in);

        // rob_clear at E2 of a fetch aborts it
        if_signal = 1'b1;
        if_addr = 32'h0000_0040;
        @(negedge clk_in);
        @(negedge clk_in);
        rob_clear = 1'b1;
        if_signal = 1'b0;
        @(negedge clk_in);
        rob_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            chk("abort_no_if_done", {31'd0, if_done}, 32'd0);
        end

        // rob_clear at E1 of a 4-byte store is ignored
        fork
            lsb_req(1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 32'd0, 4, 0);
            begin
                @(negedge clk_in);
                rob_clear = 1'b1;
                @(negedge clk_in);
                rob_clear = 1'b0;
            end
        join
        @(negedge clk_in);

        // UART store with buffer full for 5 cycles
        io_buffer_full = 1'b1;
        fork
`ifdef MEM_CTRL_IO_STALL_EN
            lsb_req(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041, 32'd0, 6, 5);
`else
            lsb_req(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041, 32'd0, 1, 0);
`endif
            begin
                repeat (5) @(negedge clk_in);
                io_buffer_full = 1'b0;
            end
        join
        io_buffer_full = 1'b0;
        @(negedge clk_in);

        // Address wrap across 0xFFFFFFFF
        lsb_req(1'b0, 2'b10, 32'hFFFF_FFFE, 32'd0, 32'h8170_6f5e, 4, 0);
        @(negedge clk_in);

        // rdy_in low mid-read: edges frozen
        fork
            lsb_req(1'b0, 2'b10, 32'h0000_0040, 32'd0, 32'hd4c3_b2a1, 4, 0);
            begin
                @(negedge clk_in);
                @(negedge clk_in);
                rdy_in = 1'b0;
                repeat (2) @(negedge clk_in);
                rdy_in = 1'b1;
            end
        join
        @(negedge clk_in);

        // rdy_in low while done is high stretches the pulse
        fork
            lsb_req(1'b0, 2'b01, 32'h0000_1000, 32'd0, 32'h0000_2211, 2, 0);
            begin
                seen = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk_in);
                    if (lsb_done) begin
                        seen = 1'b1;
                        break;
                    end
                end
                rdy_in = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_in);
                    chk("done_held", {31'd0, lsb_done}, {31'd0, seen});
                end
                rdy_in = 1'b1;
            end
        join
        @(negedge clk_in);
        chk("done_cleared", {31'd0, lsb_done}, 32'd0);

        // Asynchronous reset mid-read
        lsb_signal = 1'b1;
        lsb_wr = 1'b0;
        lsb_len = 2'b10;
        lsb_addr = 32'h0000_0040;
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("arst_if_data", if_data, 32'd0);
        chk("arst_lsb_din", lsb_din, 32'd0);
        chk("arst_lsb_done", {31'd0, lsb_done}, 32'd0);
        @(negedge clk_in);
        lsb_signal = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        lsb_req(1'b0, 2'b10, 32'h0000_1000, 32'd0, 32'h4433_2211, 4, 0);

        repeat (5) @(negedge clk_in);
        chk("lsb_q_left", lsb_q.size(), 32'd0);
        chk("if_q_left", if_q.size(), 32'd0);
        chk("wr_q_left", wr_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
